// File: rtl/cmsdk_ahb_dec_pkg.sv
// Shared AHB encodings, default-slave state type and elaboration helpers
// for the parametrised bus-matrix input-port decoder.
package cmsdk_ahb_dec_pkg;

   localparam logic [1:0] TRN_IDLE   = 2'b00;
   localparam logic [1:0] TRN_BUSY   = 2'b01;
   localparam logic [1:0] TRN_NONSEQ = 2'b10;
   localparam logic [1:0] TRN_SEQ    = 2'b11;

   localparam logic [1:0] RSP_OKAY   = 2'b00;
   localparam logic [1:0] RSP_ERROR  = 2'b01;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/cmsdk_ahb_dec_default_slave.sv
// Built-in default slave: two-cycle ERROR response for NONSEQ/SEQ transfers
// that decode to no region, plus a saturating count of such accesses.
module cmsdk_ahb_dec_default_slave
   import cmsdk_ahb_dec_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sel,
   input  logic        i_ready,
   input  logic        i_trans_nsq,
   output logic        o_readyout,
   output logic [1:0]  o_resp,
   output logic [15:0] o_cnt
);

   ds_state_e   r_state;
   ds_state_e   w_next;
   logic [15:0] r_cnt;
   logic        w_req;
   logic        w_err_start;

   assign w_req = i_sel & i_ready & i_trans_nsq;

   always_comb begin
      w_next     = r_state;
      o_readyout = 1'b1;
      o_resp     = RSP_OKAY;
      case (r_state)
         DS_IDLE: if (w_req) w_next = DS_ERR1;
         DS_ERR1: begin
            o_readyout = 1'b0;
            o_resp     = RSP_ERROR;
            w_next     = DS_ERR2;
         end
         DS_ERR2: begin
            o_resp = RSP_ERROR;
            w_next = w_req ? DS_ERR1 : DS_IDLE;
         end
         default: w_next = DS_IDLE;
      endcase
   end

   // Every entry into ERR1 is a fresh unmapped access.
   assign w_err_start = (w_next == DS_ERR1) && (r_state != DS_ERR1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= DS_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_err_start && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/cmsdk_ahb_param_decoder.sv
// AHB matrix input-port decoder: region-table address decode, data-phase
// owner tracking and response multiplexing with an integrated default slave.
module cmsdk_ahb_param_decoder
   import cmsdk_ahb_dec_pkg::*;
#(
   parameter int                                   NUM_PORTS    = 2,
   parameter int                                   NUM_REGIONS  = 4,
   parameter int                                   ADDR_LSB     = 10,
   parameter logic [NUM_REGIONS*(32-ADDR_LSB)-1:0] REGION_BASE  = '0,
   parameter logic [NUM_REGIONS*(32-ADDR_LSB)-1:0] REGION_LIMIT = '0,
   parameter logic [NUM_REGIONS*3-1:0]             REGION_PORT  = '0,
   parameter logic [NUM_REGIONS-1:0]               REGION_REMAP = '0
)(
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      remapping_dec,
   input  logic                      HREADYS,
   input  logic                      sel_dec,
   input  logic [31-ADDR_LSB:0]      decode_addr_dec,
   input  logic [1:0]                trans_dec,
   input  logic [NUM_PORTS-1:0]      active_dec_i,
   input  logic [NUM_PORTS-1:0]      readyout_dec_i,
   input  logic [2*NUM_PORTS-1:0]    resp_dec_i,
   input  logic [32*NUM_PORTS-1:0]   rdata_dec_i,
   input  logic [32*NUM_PORTS-1:0]   ruser_dec_i,
   output logic [NUM_PORTS-1:0]      sel_dec_o,
   output logic                      active_dec,
   output logic                      HREADYOUTS,
   output logic [1:0]                HRESPS,
   output logic [31:0]               HRDATAS,
   output logic [31:0]               HRUSERS,
   output logic [15:0]               unmapped_cnt
);

   localparam int            AW  = 32 - ADDR_LSB;
   localparam int            PW  = clog2(NUM_PORTS + 1);
   localparam logic [PW-1:0] DFT = PW'(NUM_PORTS);

   logic [PW-1:0] w_dec_port;
   logic [PW-1:0] w_addr_port;
   logic [PW-1:0] r_data_port;
   logic [2:0]    w_rport;
   logic          w_dft_sel;
   logic          w_ds_ready;
   logic [1:0]    w_ds_resp;

   // Walk from the top entry down so the lowest matching index wins.
   always_comb begin
      w_dec_port = DFT;
      w_rport    = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((decode_addr_dec >= REGION_BASE[i*AW +: AW]) &&
             (decode_addr_dec <= REGION_LIMIT[i*AW +: AW]) &&
             (!REGION_REMAP[i] || remapping_dec)) begin
            w_rport    = REGION_PORT[i*3 +: 3];
            w_dec_port = (int'(w_rport) < NUM_PORTS) ? w_rport[PW-1:0] : DFT;
         end
      end
   end

   // An IDLE keeps pointing at the current data-phase owner so a waited
   // slave never sees its select drop mid-transfer.
   assign w_addr_port = ((trans_dec == TRN_IDLE) && (r_data_port != DFT)) ?
                        r_data_port : w_dec_port;

   always_comb begin
      sel_dec_o  = '0;
      active_dec = 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_addr_port == PW'(p)) begin
            sel_dec_o[p] = sel_dec;
            active_dec   = active_dec_i[p];
         end
      end
   end

   assign w_dft_sel = sel_dec & (w_addr_port == DFT);

   always_ff @(posedge HCLK) begin
      if (HRESET)       r_data_port <= '0;
      else if (HREADYS) r_data_port <= w_addr_port;
   end

   always_comb begin
      HREADYOUTS = w_ds_ready;
      HRESPS     = w_ds_resp;
      HRDATAS    = '0;
      HRUSERS    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (r_data_port == PW'(p)) begin
            HREADYOUTS = readyout_dec_i[p];
            HRESPS     = resp_dec_i[p*2 +: 2];
            HRDATAS    = rdata_dec_i[p*32 +: 32];
            HRUSERS    = ruser_dec_i[p*32 +: 32];
         end
      end
   end

   cmsdk_ahb_dec_default_slave u_dft (
      .i_clk       (HCLK),
      .i_rst       (HRESET),
      .i_sel       (w_dft_sel),
      .i_ready     (HREADYS),
      .i_trans_nsq (trans_dec[1]),
      .o_readyout  (w_ds_ready),
      .o_resp      (w_ds_resp),
      .o_cnt       (unmapped_cnt)
   );

endmodule

// File: tb/tb_cmsdk_ahb_param_decoder.sv
// Self-checking bench for cmsdk_ahb_param_decoder; HREADYS is looped back
// from HREADYOUTS as the matrix would do.
module tb_cmsdk_ahb_param_decoder;
   import cmsdk_ahb_dec_pkg::*;

   localparam logic [87:0] R_BASE  = {22'h200000, 22'h0C0000, 22'h000000, 22'h000000};
   localparam logic [87:0] R_LIMIT = {22'h20FFFF, 22'h13FFFF, 22'h07FFFF, 22'h00003F};
   localparam logic [11:0] R_PORT  = {3'd5, 3'd1, 3'd0, 3'd1};
   localparam logic [3:0]  R_REMAP = 4'b0001;

   localparam logic [31:0] RD0 = 32'hA0A0_0000, RD1 = 32'hB1B1_1111;
   localparam logic [31:0] RU0 = 32'hC0C0_0C0C, RU1 = 32'hD1D1_1D1D;
   localparam logic [21:0] A_P1 = 22'h0C0000;   // HADDR 0x30000000
   localparam logic [21:0] A_UN = 22'h180000;   // HADDR 0x60000000
   localparam logic [21:0] A_P0 = 22'h001000;

   logic        HCLK = 1'b0;
   logic        HRESET, remapping_dec, HREADYS, sel_dec;
   logic [21:0] decode_addr_dec;
   logic [1:0]  trans_dec;
   logic [1:0]  active_dec_i, readyout_dec_i;
   logic [3:0]  resp_dec_i;
   logic [63:0] rdata_dec_i, ruser_dec_i;
   logic [1:0]  sel_dec_o;
   logic        active_dec, HREADYOUTS;
   logic [1:0]  HRESPS;
   logic [31:0] HRDATAS, HRUSERS;
   logic [15:0] unmapped_cnt;

   typedef logic [82:0] dp_t;
   typedef struct {
      logic rst, remap, sel;
      logic [21:0] addr;
      logic [1:0] trans, rdy, esel;
      logic ca, eact, push;
      dp_t edp;
   } vec_t;

   int  n_chk = 0, n_fail = 0;
   dp_t sb[$];
   dp_t e_dp;
   dp_t w_obs;

   assign HREADYS = HREADYOUTS;
   assign w_obs   = {HREADYOUTS, HRESPS, HRDATAS, HRUSERS, unmapped_cnt};

   always #5 HCLK = ~HCLK;

   cmsdk_ahb_param_decoder #(
      .NUM_PORTS(2), .NUM_REGIONS(4), .ADDR_LSB(10),
      .REGION_BASE(R_BASE), .REGION_LIMIT(R_LIMIT),
      .REGION_PORT(R_PORT), .REGION_REMAP(R_REMAP)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .remapping_dec(remapping_dec),
      .HREADYS(HREADYS), .sel_dec(sel_dec), .decode_addr_dec(decode_addr_dec),
      .trans_dec(trans_dec), .active_dec_i(active_dec_i),
      .readyout_dec_i(readyout_dec_i), .resp_dec_i(resp_dec_i),
      .rdata_dec_i(rdata_dec_i), .ruser_dec_i(ruser_dec_i),
      .sel_dec_o(sel_dec_o), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
      .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS),
      .unmapped_cnt(unmapped_cnt)
   );

   function automatic dp_t P0(input logic [15:0] c); return {1'b1, RSP_OKAY, RD0, RU0, c}; endfunction
   function automatic dp_t P1(input logic [15:0] c); return {1'b1, RSP_OKAY, RD1, RU1, c}; endfunction
   function automatic dp_t P1W(input logic [15:0] c); return {1'b0, RSP_OKAY, RD1, RU1, c}; endfunction
   function automatic dp_t E1(input logic [15:0] c); return {1'b0, RSP_ERROR, 32'h0, 32'h0, c}; endfunction
   function automatic dp_t E2(input logic [15:0] c); return {1'b1, RSP_ERROR, 32'h0, 32'h0, c}; endfunction
   function automatic dp_t DOK(input logic [15:0] c); return {1'b1, RSP_OKAY, 32'h0, 32'h0, c}; endfunction

   function automatic vec_t mk(input logic rst, input logic remap, input logic sel,
                               input logic [21:0] addr, input logic [1:0] trans,
                               input logic [1:0] rdy, input logic [1:0] esel,
                               input logic ca, input logic eact, input logic push,
                               input dp_t edp);
      vec_t v;
      v.rst = rst; v.remap = remap; v.sel = sel; v.addr = addr; v.trans = trans;
      v.rdy = rdy; v.esel = esel; v.ca = ca; v.eact = eact; v.push = push; v.edp = edp;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      HRESET = v.rst; remapping_dec = v.remap; sel_dec = v.sel;
      decode_addr_dec = v.addr; trans_dec = v.trans; readyout_dec_i = v.rdy;
   endtask

   task automatic do_reset();
      HRESET = 1'b1; sel_dec = 1'b0; trans_dec = TRN_IDLE;
      @(posedge HCLK); #1;
      HRESET = 1'b0;
   endtask

   task automatic test_reset();
      HRESET = 1'b1; readyout_dec_i = 2'b10; resp_dec_i = 4'b0001;
      @(posedge HCLK); @(posedge HCLK); #1;
      @(negedge HCLK);
      n_chk++;
      if (sel_dec_o !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b exp 00", sel_dec_o); end
      n_chk++;
      if (w_obs !== {1'b0, 2'b01, RD0, RU0, 16'h0}) begin
         n_fail++; $display("FAIL reset_port0: got %h exp %h", w_obs, {1'b0, 2'b01, RD0, RU0, 16'h0});
      end
      @(posedge HCLK); #1;
      HRESET = 1'b0; readyout_dec_i = 2'b11; resp_dec_i = 4'b0000;
      @(negedge HCLK);
      n_chk++;
      if (w_obs !== P0(16'h0)) begin n_fail++; $display("FAIL reset_release: got %h exp %h", w_obs, P0(16'h0)); end
      @(posedge HCLK); #1;
   endtask

   task automatic test_port_select();
      vec_t tv[$];
      tv.push_back(mk(0, 0, 1, A_P1, TRN_NONSEQ, 2'b11, 2'b10, 1, 1, 1, P1(16'd0)));
      tv.push_back(mk(0, 0, 1, A_P0, TRN_NONSEQ, 2'b11, 2'b01, 1, 0, 1, P0(16'd0)));
      tv.push_back(mk(0, 0, 0, A_P0, TRN_IDLE,   2'b11, 2'b00, 1, 0, 0, '0));
      foreach (tv[i]) begin
         apply(tv[i]);
         @(negedge HCLK);
         n_chk++;
         if (sel_dec_o !== tv[i].esel) begin n_fail++; $display("FAIL port_sel[%0d]: got %b exp %b", i, sel_dec_o, tv[i].esel); end
         if (tv[i].ca) begin
            n_chk++;
            if (active_dec !== tv[i].eact) begin n_fail++; $display("FAIL port_active[%0d]: got %b exp %b", i, active_dec, tv[i].eact); end
         end
         if (sb.size() > 0) begin
            e_dp = sb.pop_front(); n_chk++;
            if (w_obs !== e_dp) begin n_fail++; $display("FAIL port_data[%0d]: got %h exp %h", i, w_obs, e_dp); end
         end
         if (tv[i].push) sb.push_back(tv[i].edp);
         @(posedge HCLK); #1;
      end
   endtask

   task automatic test_unmapped();
      vec_t tv[$];
      tv.push_back(mk(0, 0, 1, A_UN, TRN_NONSEQ, 2'b11, 2'b00, 1, 1, 1, E1(16'd1)));
      tv.push_back(mk(0, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 1, E2(16'd1)));
      tv.push_back(mk(0, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 1, DOK(16'd1)));
      tv.push_back(mk(0, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 0, '0));
      foreach (tv[i]) begin
         apply(tv[i]);
         @(negedge HCLK);
         n_chk++;
         if (sel_dec_o !== tv[i].esel) begin n_fail++; $display("FAIL unmapped_sel[%0d]: got %b exp %b", i, sel_dec_o, tv[i].esel); end
         if (tv[i].ca) begin
            n_chk++;
            if (active_dec !== tv[i].eact) begin n_fail++; $display("FAIL unmapped_active[%0d]: got %b exp %b", i, active_dec, tv[i].eact); end
         end
         if (sb.size() > 0) begin
            e_dp = sb.pop_front(); n_chk++;
            if (w_obs !== e_dp) begin n_fail++; $display("FAIL unmapped_data[%0d]: got %h exp %h", i, w_obs, e_dp); end
         end
         if (tv[i].push) sb.push_back(tv[i].edp);
         @(posedge HCLK); #1;
      end
   endtask

   task automatic test_remap();
      vec_t tv[$];
      tv.push_back(mk(0, 1, 1, 22'h0, TRN_NONSEQ, 2'b11, 2'b10, 1, 1, 1, P1(16'd1)));
      tv.push_back(mk(0, 0, 1, 22'h0, TRN_NONSEQ, 2'b11, 2'b01, 1, 0, 1, P0(16'd1)));
      tv.push_back(mk(0, 0, 0, 22'h0, TRN_IDLE,   2'b11, 2'b00, 0, 0, 0, '0));
      foreach (tv[i]) begin
         apply(tv[i]);
         @(negedge HCLK);
         n_chk++;
         if (sel_dec_o !== tv[i].esel) begin n_fail++; $display("FAIL remap_sel[%0d]: got %b exp %b", i, sel_dec_o, tv[i].esel); end
         if (tv[i].ca) begin
            n_chk++;
            if (active_dec !== tv[i].eact) begin n_fail++; $display("FAIL remap_active[%0d]: got %b exp %b", i, active_dec, tv[i].eact); end
         end
         if (sb.size() > 0) begin
            e_dp = sb.pop_front(); n_chk++;
            if (w_obs !== e_dp) begin n_fail++; $display("FAIL remap_data[%0d]: got %h exp %h", i, w_obs, e_dp); end
         end
         if (tv[i].push) sb.push_back(tv[i].edp);
         @(posedge HCLK); #1;
      end
   endtask

   task automatic test_wait_hold();
      vec_t tv[$];
      tv.push_back(mk(0, 0, 1, A_P1, TRN_NONSEQ, 2'b11, 2'b10, 1, 1, 1, P1W(16'd1)));
      tv.push_back(mk(0, 0, 1, A_UN, TRN_IDLE,   2'b01, 2'b10, 1, 1, 1, P1W(16'd1)));
      tv.push_back(mk(0, 0, 1, A_UN, TRN_IDLE,   2'b01, 2'b10, 1, 1, 1, P1W(16'd1)));
      tv.push_back(mk(0, 0, 1, A_UN, TRN_IDLE,   2'b01, 2'b10, 1, 1, 1, P1(16'd1)));
      tv.push_back(mk(0, 0, 1, A_UN, TRN_IDLE,   2'b11, 2'b10, 1, 1, 0, '0));
      tv.push_back(mk(0, 0, 0, A_P0, TRN_IDLE,   2'b11, 2'b00, 0, 0, 0, '0));
      foreach (tv[i]) begin
         apply(tv[i]);
         @(negedge HCLK);
         n_chk++;
         if (sel_dec_o !== tv[i].esel) begin n_fail++; $display("FAIL hold_sel[%0d]: got %b exp %b", i, sel_dec_o, tv[i].esel); end
         if (tv[i].ca) begin
            n_chk++;
            if (active_dec !== tv[i].eact) begin n_fail++; $display("FAIL hold_active[%0d]: got %b exp %b", i, active_dec, tv[i].eact); end
         end
         if (sb.size() > 0) begin
            e_dp = sb.pop_front(); n_chk++;
            if (w_obs !== e_dp) begin n_fail++; $display("FAIL hold_data[%0d]: got %h exp %h", i, w_obs, e_dp); end
         end
         if (tv[i].push) sb.push_back(tv[i].edp);
         @(posedge HCLK); #1;
      end
   endtask

   // BUSY transfers sweep region edges without starting any ERROR response.
   task automatic test_decode_boundary();
      vec_t tv[$];
      tv.push_back(mk(0, 0, 1, 22'h07FFFF, TRN_BUSY, 2'b11, 2'b01, 1, 0, 0, '0));
      tv.push_back(mk(0, 0, 1, 22'h080000, TRN_BUSY, 2'b11, 2'b00, 1, 1, 0, '0));
      tv.push_back(mk(0, 0, 1, 22'h0BFFFF, TRN_BUSY, 2'b11, 2'b00, 1, 1, 0, '0));
      tv.push_back(mk(0, 0, 1, 22'h0C0000, TRN_BUSY, 2'b11, 2'b10, 1, 1, 0, '0));
      tv.push_back(mk(0, 0, 1, 22'h13FFFF, TRN_BUSY, 2'b11, 2'b10, 1, 1, 0, '0));
      tv.push_back(mk(0, 0, 1, 22'h140000, TRN_BUSY, 2'b11, 2'b00, 1, 1, 0, '0));
      tv.push_back(mk(0, 0, 1, 22'h200000, TRN_BUSY, 2'b11, 2'b00, 1, 1, 0, '0));
      tv.push_back(mk(0, 1, 1, 22'h00003F, TRN_BUSY, 2'b11, 2'b10, 1, 1, 0, '0));
      tv.push_back(mk(0, 1, 1, 22'h000040, TRN_BUSY, 2'b11, 2'b01, 1, 0, 0, '0));
      tv.push_back(mk(0, 0, 1, 22'h20FFFF, TRN_BUSY, 2'b11, 2'b00, 1, 1, 0, '0));
      foreach (tv[i]) begin
         apply(tv[i]);
         @(negedge HCLK);
         n_chk++;
         if (sel_dec_o !== tv[i].esel) begin n_fail++; $display("FAIL bound_sel[%0d]: got %b exp %b", i, sel_dec_o, tv[i].esel); end
         if (tv[i].ca) begin
            n_chk++;
            if (active_dec !== tv[i].eact) begin n_fail++; $display("FAIL bound_active[%0d]: got %b exp %b", i, active_dec, tv[i].eact); end
         end
         if (sb.size() > 0) begin
            e_dp = sb.pop_front(); n_chk++;
            if (w_obs !== e_dp) begin n_fail++; $display("FAIL bound_data[%0d]: got %h exp %h", i, w_obs, e_dp); end
         end
         if (tv[i].push) sb.push_back(tv[i].edp);
         @(posedge HCLK); #1;
      end
      @(negedge HCLK);
      n_chk++;
      if (w_obs !== DOK(16'd1)) begin n_fail++; $display("FAIL bound_busy_okay: got %h exp %h", w_obs, DOK(16'd1)); end
      @(posedge HCLK); #1;
   endtask

   task automatic test_back_to_back();
      vec_t tv[$];
      tv.push_back(mk(1, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 0, '0));
      tv.push_back(mk(0, 0, 1, A_UN, TRN_NONSEQ, 2'b11, 2'b00, 1, 1, 1, E1(16'd1)));
      tv.push_back(mk(0, 0, 1, A_UN, TRN_NONSEQ, 2'b11, 2'b00, 0, 0, 1, E2(16'd1)));
      tv.push_back(mk(0, 0, 1, A_UN, TRN_NONSEQ, 2'b11, 2'b00, 0, 0, 1, E1(16'd2)));
      tv.push_back(mk(0, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 1, E2(16'd2)));
      tv.push_back(mk(0, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 1, DOK(16'd2)));
      tv.push_back(mk(0, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 0, '0));
      foreach (tv[i]) begin
         apply(tv[i]);
         @(negedge HCLK);
         n_chk++;
         if (sel_dec_o !== tv[i].esel) begin n_fail++; $display("FAIL b2b_sel[%0d]: got %b exp %b", i, sel_dec_o, tv[i].esel); end
         if (tv[i].ca) begin
            n_chk++;
            if (active_dec !== tv[i].eact) begin n_fail++; $display("FAIL b2b_active[%0d]: got %b exp %b", i, active_dec, tv[i].eact); end
         end
         if (sb.size() > 0) begin
            e_dp = sb.pop_front(); n_chk++;
            if (w_obs !== e_dp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, w_obs, e_dp); end
         end
         if (tv[i].push) sb.push_back(tv[i].edp);
         @(posedge HCLK); #1;
      end
   endtask

   task automatic test_saturate_reset();
      vec_t tv[$];
      do_reset();
      force dut.u_dft.r_cnt = 16'hFFFE;
      #1;
      release dut.u_dft.r_cnt;
      tv.push_back(mk(0, 0, 1, A_UN, TRN_NONSEQ, 2'b11, 2'b00, 0, 0, 1, E1(16'hFFFF)));
      tv.push_back(mk(0, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 1, E2(16'hFFFF)));
      tv.push_back(mk(0, 0, 1, A_UN, TRN_NONSEQ, 2'b11, 2'b00, 0, 0, 1, E1(16'hFFFF)));
      tv.push_back(mk(1, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 1, P0(16'h0)));
      tv.push_back(mk(0, 0, 0, A_UN, TRN_IDLE,   2'b11, 2'b00, 0, 0, 0, '0));
      foreach (tv[i]) begin
         apply(tv[i]);
         @(negedge HCLK);
         n_chk++;
         if (sel_dec_o !== tv[i].esel) begin n_fail++; $display("FAIL sat_sel[%0d]: got %b exp %b", i, sel_dec_o, tv[i].esel); end
         if (tv[i].ca) begin
            n_chk++;
            if (active_dec !== tv[i].eact) begin n_fail++; $display("FAIL sat_active[%0d]: got %b exp %b", i, active_dec, tv[i].eact); end
         end
         if (sb.size() > 0) begin
            e_dp = sb.pop_front(); n_chk++;
            if (w_obs !== e_dp) begin n_fail++; $display("FAIL sat_data[%0d]: got %h exp %h", i, w_obs, e_dp); end
         end
         if (tv[i].push) sb.push_back(tv[i].edp);
         @(posedge HCLK); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t exp below 200000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      HRESET = 1'b1; remapping_dec = 1'b0; sel_dec = 1'b0;
      decode_addr_dec = '0; trans_dec = TRN_IDLE;
      active_dec_i = 2'b10; readyout_dec_i = 2'b11; resp_dec_i = 4'b0000;
      rdata_dec_i = {RD1, RD0}; ruser_dec_i = {RU1, RU0};
      test_reset();
      test_port_select();
      test_unmapped();
      test_remap();
      test_wait_hold();
      test_decode_boundary();
      test_back_to_back();
      test_saturate_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
